// File: rtl/contador_updown_pkg.sv
// Shared constants for the up/down counter.
// Direction encoding and default width.
package contador_updown_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/contador_updown_if.sv
// Counter control/observation bundle.
// master drives act/updown, slave returns out/tc.
interface contador_updown_if
    import contador_updown_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
);

    logic act;
    logic updown;
    logic [WIDTH-1:0] out;
    logic tc;

    modport master (
        output act,
        output updown,
        input out,
        input tc
    );

    modport slave (
        input act,
        input updown,
        output out,
        output tc
    );

endinterface

// File: rtl/contador_updown_step.sv
// Next-state logic: wrap, or saturate when
// CONTADOR_UPDOWN_SATURATE_EN is defined.
module contador_updown_step
    import contador_updown_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input logic [WIDTH-1:0] cur,
    input logic updown,
    input logic act,
    output logic [WIDTH-1:0] nxt,
    output logic tc
);

    logic at_max;
    logic at_min;

    assign at_max = &cur;
    assign at_min = ~|cur;

    always_comb begin
        nxt = cur;
        tc = 1'b0;
        unique case (1'b1)
            !act: begin
                nxt = cur;
            end
            act && (updown == DIR_UP): begin
                tc = at_max;
`ifdef CONTADOR_UPDOWN_SATURATE_EN
                nxt = at_max ? cur : cur + WIDTH'(1);
`else
                nxt = cur + WIDTH'(1);
`endif
            end
            act && (updown == DIR_DOWN): begin
                tc = at_min;
`ifdef CONTADOR_UPDOWN_SATURATE_EN
                nxt = at_min ? cur : cur - WIDTH'(1);
`else
                nxt = cur - WIDTH'(1);
`endif
            end
            default: begin
                nxt = cur;
            end
        endcase
    end

endmodule

// File: rtl/contador_updown.sv
// Up/down counter with terminal-count pulse.
// Optional saturation: CONTADOR_UPDOWN_SATURATE_EN.
module contador_updown
    import contador_updown_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input logic clk,
    input logic reset,
    contador_updown_if.slave bus
);

    logic [WIDTH-1:0] cnt;
    logic tc_q;
    logic [WIDTH-1:0] nxt;
    logic tc_d;

    contador_updown_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur(cnt),
        .updown(bus.updown),
        .act(bus.act),
        .nxt(nxt),
        .tc(tc_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            tc_q <= 1'b0;
        end else begin
            cnt <= nxt;
            tc_q <= tc_d;
        end
    end

    assign bus.out = cnt;
    assign bus.tc = tc_q;

endmodule

// File: tb/tb_contador_updown.sv
// Randomised + directed bench for contador_updown
// against an arithmetic reference model.
module tb_contador_updown;

    localparam int W = 8;
    localparam int MAX = (1 << W) - 1;

    logic clk;
    logic reset;
    int total;
    int bad;
    bit started;

    int m_out;
    bit m_tc;

    contador_updown_if #(.WIDTH(W)) bus ();

    contador_updown #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed step, then wrap or clamp.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_out <= 0;
            m_tc <= 1'b0;
        end else if (!bus.act) begin
            m_tc <= 1'b0;
        end else begin
            automatic int n;
            n = m_out + (bus.updown ? 1 : -1);
            if (n < 0 || n > MAX) begin
                m_tc <= 1'b1;
`ifdef CONTADOR_UPDOWN_SATURATE_EN
                m_out <= m_out;
`else
                m_out <= (n + MAX + 1) % (MAX + 1);
`endif
            end else begin
                m_tc <= 1'b0;
                m_out <= n;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            total++;
            if (int'(bus.out) != m_out || bus.tc !== m_tc) begin
                bad++;
                $display("FAIL model t=%0t out=%0d tc=%0b want out=%0d tc=%0b",
                         $time, bus.out, bus.tc, m_out, m_tc);
            end
        end
    end

    task automatic expect_val(string nm, int eo, bit et);
        total++;
        if (int'(bus.out) != eo || bus.tc !== et) begin
            bad++;
            $display("FAIL %s out=%0d tc=%0b want out=%0d tc=%0b",
                     nm, bus.out, bus.tc, eo, et);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.act = 1'b0;
        tick(1);
        reset = 1'b1;
    endtask

    int tc_seen;

    initial begin
        total = 0;
        bad = 0;
        started = 1'b0;
        reset = 1'b0;
        bus.act = 1'b1;
        bus.updown = 1'b1;
        #1;
        expect_val("async_reset_t0", 0, 1'b0);
        started = 1'b1;
        tick(2);
        expect_val("reset_hold", 0, 1'b0);

        reset = 1'b1;
        tick(10);
        expect_val("up_10", 10, 1'b0);
        tick(245);
        expect_val("up_255", 255, 1'b0);
        tick(1);
`ifdef CONTADOR_UPDOWN_SATURATE_EN
        expect_val("sat_top", 255, 1'b1);
`else
        expect_val("wrap_top", 0, 1'b1);
`endif

        do_reset();
        bus.act = 1'b1;
        bus.updown = 1'b1;
        tick(37);
        bus.act = 1'b0;
        tick(20);
        expect_val("hold_37", 37, 1'b0);
        bus.act = 1'b1;
        tick(1);
        expect_val("resume_38", 38, 1'b0);

        do_reset();
        bus.act = 1'b1;
        bus.updown = 1'b0;
        tick(1);
`ifdef CONTADOR_UPDOWN_SATURATE_EN
        expect_val("sat_bot", 0, 1'b1);
        tick(2);
        expect_val("sat_bot2", 0, 1'b1);
`else
        expect_val("wrap_bot", 255, 1'b1);
        tick(1);
        expect_val("down_254", 254, 1'b0);
        tick(1);
        expect_val("down_253", 253, 1'b0);
`endif

        do_reset();
        bus.act = 1'b1;
        bus.updown = 1'b1;
        tick(100);
        expect_val("up_100", 100, 1'b0);
        bus.updown = 1'b0;
        tick(1);
        expect_val("flip_99", 99, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        expect_val("async_mid", 0, 1'b0);
        tick(1);
        reset = 1'b1;

        do_reset();
        bus.act = 1'b1;
        bus.updown = 1'b1;
        tc_seen = 0;
        for (int i = 0; i < 250; i++) begin
            tick(1);
            if (bus.tc) tc_seen++;
        end
        expect_val("run_up_250", 250, 1'b0);
        bus.updown = 1'b0;
        for (int i = 0; i < 250; i++) begin
            tick(1);
            if (bus.tc) tc_seen++;
        end
        expect_val("run_down_0", 0, 1'b0);
        total++;
        if (tc_seen != 0) begin
            bad++;
            $display("FAIL run_tc tc_pulses=%0d want 0", tc_seen);
        end

        // Random walk with slow direction bias so limits get hit.
        for (int i = 0; i < 4000; i++) begin
            automatic bit bias = ((i / 400) % 2) == 0;
            @(negedge clk);
            bus.act = ($urandom_range(0, 3) != 0);
            bus.updown = ($urandom_range(0, 9) < 8) ? bias : ~bias;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #1;
                expect_val("rand_async", 0, 1'b0);
                @(negedge clk);
                reset = 1'b1;
            end
        end
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
